// File: rtl/fetch_stage.sv
// fetch_stage: owns the fetch PC, issues credit-gated reads to a 1-cycle ROM and buffers the returned
// words in a head-registered FIFO feeding decode. Optional counters are built under FETCH_PERF_CNT_EN.

module fetch_stage #(
    parameter logic [11:0] RESET_PC  = 12'o4000,
    parameter int unsigned DEPTH     = 4,
    parameter logic [14:0] NOP_INSTR = 15'o30000
) (
    input  logic        clock,
    input  logic        rst,
    output logic        imem_rd_en,
    output logic [11:0] imem_addr,
    input  logic [14:0] imem_data,
    input  logic        ready_D,
    input  logic        br_taken,
    input  logic [11:0] br_target,
    input  logic        halt_E,
    input  logic [2:0]  fb_in,
    input  logic [2:0]  eb_in,
    output logic [14:0] instr_D,
    output logic [11:0] pc_D,
    output logic [2:0]  bits_FB,
    output logic [2:0]  bits_EB,
    output logic        valid_D,
    output logic        flush,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW+1:0] DEPTH_LIM = (AW+2)'(DEPTH);

    typedef struct packed {
        logic [14:0] instr;
        logic [11:0] pc;
        logic [2:0]  fb;
        logic [2:0]  eb;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [AW+1:0] credit_used;
    logic [11:0]   fpc;
    logic [11:0]   issue_pc;
    logic          inflight;
    logic          halted;
    logic          flush_q;
    logic          push;
    logic          pop;

    // A read is only issued when a FIFO slot is guaranteed for its return word.
    always_comb begin
        credit_used = {1'b0, count} + {{(AW+1){1'b0}}, inflight};
        imem_rd_en  = !rst && !halted && !br_taken && (credit_used < DEPTH_LIM);
        imem_addr   = fpc;
        valid_D     = (count != '0);
        head        = mem[rd_ptr];
        instr_D     = valid_D ? head.instr : NOP_INSTR;
        pc_D        = valid_D ? head.pc    : '0;
        bits_FB     = valid_D ? head.fb    : '0;
        bits_EB     = valid_D ? head.eb    : '0;
        flush       = flush_q;
        // A word returning during a redirect cycle belongs to the old path and is dropped.
        push        = inflight && !br_taken;
        pop         = valid_D && ready_D && !br_taken;
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            fpc      <= RESET_PC;
            issue_pc <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= 1'b0;
            halted   <= 1'b0;
            flush_q  <= 1'b0;
        end else begin
            flush_q  <= br_taken;
            inflight <= imem_rd_en;
            if (halt_E) begin
                halted <= 1'b1;
            end
            if (br_taken) begin
                fpc    <= br_target;
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (imem_rd_en) begin
                    fpc      <= fpc + 12'd1;
                    issue_pc <= fpc;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {imem_data, issue_pc, fb_in, eb_in};
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (pop) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (!valid_D && !halted) begin
                perf_bubbles <= perf_bubbles + 32'd1;
            end
        end
    end
`else
    assign perf_fetched = '0;
    assign perf_bubbles = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: per-cycle vector table plus hand sequences for
// PC wrap, halt drain, redirect while halted and the performance counters.

module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        rst;
    logic        ready_D;
    logic        br_taken;
    logic [11:0] br_target;
    logic        halt_E;
    logic [2:0]  fb_in;
    logic [2:0]  eb_in;

    logic        imem_rd_en;
    logic [11:0] imem_addr;
    logic [14:0] imem_data;
    logic [14:0] instr_D;
    logic [11:0] pc_D;
    logic [2:0]  bits_FB;
    logic [2:0]  bits_EB;
    logic        valid_D;
    logic        flush;
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;

    logic        w_rd_en;
    logic [11:0] w_addr;
    logic [14:0] w_data;
    logic [14:0] w_instr;
    logic [11:0] w_pc;
    logic [2:0]  w_fb;
    logic [2:0]  w_eb;
    logic        w_valid;
    logic        w_flush;
    logic [31:0] w_pf;
    logic [31:0] w_pb;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    function automatic logic [14:0] rom_word(input logic [11:0] a);
        return {a[2:0] ^ 3'b110, a ^ 12'o5252};
    endfunction

    always_ff @(posedge clock) begin
        if (imem_rd_en) imem_data <= rom_word(imem_addr);
        if (w_rd_en)    w_data    <= rom_word(w_addr);
    end

    fetch_stage #(.RESET_PC(12'o4000), .DEPTH(4), .NOP_INSTR(15'o30000)) dut (
        .clock(clock), .rst(rst), .imem_rd_en(imem_rd_en), .imem_addr(imem_addr),
        .imem_data(imem_data), .ready_D(ready_D), .br_taken(br_taken), .br_target(br_target),
        .halt_E(halt_E), .fb_in(fb_in), .eb_in(eb_in), .instr_D(instr_D), .pc_D(pc_D),
        .bits_FB(bits_FB), .bits_EB(bits_EB), .valid_D(valid_D), .flush(flush),
        .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
    );

    fetch_stage #(.RESET_PC(12'o7776), .DEPTH(4), .NOP_INSTR(15'o30000)) dut_wrap (
        .clock(clock), .rst(rst), .imem_rd_en(w_rd_en), .imem_addr(w_addr),
        .imem_data(w_data), .ready_D(ready_D), .br_taken(br_taken), .br_target(br_target),
        .halt_E(halt_E), .fb_in(fb_in), .eb_in(eb_in), .instr_D(w_instr), .pc_D(w_pc),
        .bits_FB(w_fb), .bits_EB(w_eb), .valid_D(w_valid), .flush(w_flush),
        .perf_fetched(w_pf), .perf_bubbles(w_pb)
    );

    typedef struct {
        logic        rst;
        logic        ready;
        logic        br;
        logic [11:0] tgt;
        logic        halt;
        logic        exp_valid;
        logic [11:0] exp_pc;
        logic        exp_rd;
        logic [11:0] exp_addr;
        logic        exp_flush;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic rdy, input logic b, input logic [11:0] t,
                                input logic h, input logic v, input logic [11:0] p,
                                input logic rd, input logic [11:0] a, input logic f);
        vec_t x;
        x.rst = r; x.ready = rdy; x.br = b; x.tgt = t; x.halt = h;
        x.exp_valid = v; x.exp_pc = p; x.exp_rd = rd; x.exp_addr = a; x.exp_flush = f;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0o expected %0o", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        rst = 1'b1; ready_D = rdy; br_taken = 1'b0; br_target = '0; halt_E = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic v, input logic [11:0] p);
        check({tag, " valid"}, 32'(valid_D), 32'(v));
        check({tag, " pc"}, 32'(pc_D), v ? 32'(p) : 32'd0);
        check({tag, " instr"}, 32'(instr_D), v ? 32'(rom_word(p)) : 32'o30000);
    endtask

    logic [31:0] exp_pf;
    logic [31:0] exp_pb;

    initial begin
        rst = 1'b1; ready_D = 1'b0; br_taken = 1'b0; br_target = '0; halt_E = 1'b0;
        fb_in = 3'd5; eb_in = 3'd2;

        // startup stream
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0,       0, 12'o4000, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,       1, 12'o4000, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,       1, 12'o4001, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 12'o4000, 1, 12'o4002, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 12'o4001, 1, 12'o4003, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 12'o4002, 1, 12'o4004, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 12'o4003, 1, 12'o4005, 0));
        // stall six cycles, then release
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,       0, 12'o4000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,       1, 12'o4000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,       1, 12'o4001, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 12'o4000, 1, 12'o4002, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 12'o4000, 1, 12'o4003, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 12'o4000, 0, 12'o4004, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 12'o4000, 0, 12'o4004, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 12'o4000, 0, 12'o4004, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 12'o4001, 1, 12'o4004, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 12'o4002, 1, 12'o4005, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 12'o4003, 1, 12'o4006, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 12'o4004, 1, 12'o4007, 0));
        // redirect to 'o2345 with a word in flight
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0,       0, 12'o4000, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,       1, 12'o4000, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,       1, 12'o4001, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 12'o4000, 1, 12'o4002, 0));
        vecs.push_back(mk(0, 1, 1, 12'o2345, 0, 1, 12'o4001, 0, 12'o4003, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,       1, 12'o2345, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,       1, 12'o2346, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 12'o2345, 1, 12'o2347, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 12'o2346, 1, 12'o2350, 0));

        tick();
        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; ready_D = vecs[i].ready; br_taken = vecs[i].br;
            br_target = vecs[i].tgt; halt_E = vecs[i].halt;
            #1;
            check_head($sformatf("v%0d", i), vecs[i].exp_valid, vecs[i].exp_pc);
            check($sformatf("v%0d bits_FB", i), 32'(bits_FB), vecs[i].exp_valid ? 32'd5 : 32'd0);
            check($sformatf("v%0d bits_EB", i), 32'(bits_EB), vecs[i].exp_valid ? 32'd2 : 32'd0);
            check($sformatf("v%0d rd_en", i), 32'(imem_rd_en), 32'(vecs[i].exp_rd));
            check($sformatf("v%0d addr", i), 32'(imem_addr), 32'(vecs[i].exp_addr));
            check($sformatf("v%0d flush", i), 32'(flush), 32'(vecs[i].exp_flush));
            tick();
        end

        // PC wrap from 'o7776
        do_reset(1'b1);
        #1;
        check("wrap c0 rd_en", 32'(w_rd_en), 32'd1);
        check("wrap c0 addr", 32'(w_addr), 32'o7776);
        tick(); #1;
        check("wrap c1 addr", 32'(w_addr), 32'o7777);
        tick(); #1;
        check("wrap c2 addr", 32'(w_addr), 32'o0000);
        check("wrap c2 pc", 32'(w_pc), 32'o7776);
        tick(); #1;
        check("wrap c3 pc", 32'(w_pc), 32'o7777);
        tick(); #1;
        check("wrap c4 valid", 32'(w_valid), 32'd1);
        check("wrap c4 pc", 32'(w_pc), 32'o0000);
        check("wrap c4 instr", 32'(w_instr), 32'(rom_word(12'o0000)));
        check("wrap c4 fb", 32'(w_fb), 32'd5);
        check("wrap c4 eb", 32'(w_eb), 32'd2);
        check("wrap c4 flush", 32'(w_flush), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        exp_pf = 32'd2; exp_pb = 32'd2;
`else
        exp_pf = 32'd0; exp_pb = 32'd0;
`endif
        check("wrap c4 perf_fetched", w_pf, exp_pf);
        check("wrap c4 perf_bubbles", w_pb, exp_pb);

        // halt with two words left buffered after FIFO filled under stall
        do_reset(1'b0);
        for (int k = 0; k < 6; k++) tick();
        ready_D = 1'b1; halt_E = 1'b1; #1;
        check_head("halt c6", 1'b1, 12'o4000);
        check("halt c6 rd_en", 32'(imem_rd_en), 32'd0);
        tick();
        halt_E = 1'b0; #1;
        check_head("halt c7", 1'b1, 12'o4001);
        check("halt c7 rd_en", 32'(imem_rd_en), 32'd0);
        tick();
        ready_D = 1'b0; #1;
        check_head("halt c8", 1'b1, 12'o4002);
        check("halt c8 rd_en", 32'(imem_rd_en), 32'd0);
        tick();
        ready_D = 1'b1; #1;
        check_head("halt c9", 1'b1, 12'o4002);
        tick(); #1;
        check_head("halt c10", 1'b1, 12'o4003);
        tick();
        for (int k = 11; k < 16; k++) begin
            #1;
            check_head($sformatf("halt c%0d", k), 1'b0, 12'o0);
            check($sformatf("halt c%0d rd_en", k), 32'(imem_rd_en), 32'd0);
            tick();
        end
        br_taken = 1'b1; br_target = 12'o0100; #1;
        check("halt br rd_en", 32'(imem_rd_en), 32'd0);
        tick();
        br_taken = 1'b0; #1;
        check("halt br+1 flush", 32'(flush), 32'd1);
        check("halt br+1 addr", 32'(imem_addr), 32'o0100);
        check("halt br+1 rd_en", 32'(imem_rd_en), 32'd0);
        tick(); #1;
        check("halt br+2 flush", 32'(flush), 32'd0);
        check_head("halt br+2", 1'b0, 12'o0);

        // counters: 10 pops, 2 startup bubbles
        do_reset(1'b1);
        #1;
        check("perf reset fetched", perf_fetched, 32'd0);
        check("perf reset bubbles", perf_bubbles, 32'd0);
        for (int k = 0; k < 12; k++) tick();
`ifdef FETCH_PERF_CNT_EN
        exp_pf = 32'd10; exp_pb = 32'd2;
`else
        exp_pf = 32'd0; exp_pb = 32'd0;
`endif
        #1;
        check("perf fetched", perf_fetched, exp_pf);
        check("perf bubbles", perf_bubbles, exp_pb);
        check_head("perf c12", 1'b1, 12'o4012);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
